// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared constants for the push-button front end: direction indices, the
// arbiter state encoding and the default debounce length.
//   DIR_*                   : bit position of each direction in 4-bit vectors
//   ST_IDLE                 : arbiter idle state; ownership states are
//                             {1'b0, direction}
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms at 25 MHz
// ---------------------------------------------------------------------------
package button_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int unsigned NUM_DIRS = 4;

  localparam logic [2:0] ST_IDLE = 3'b100;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

  // Ownership state for a direction: MSB clear, direction in the low bits.
  function automatic logic [2:0] ownState(input logic [1:0] dir);
    return {1'b0, dir};
  endfunction

  // One-hot mask selecting a single direction.
  function automatic logic [3:0] dirMask(input logic [1:0] dir);
    return 4'b0001 << dir;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
// Two-flop synchronizer followed by a stability counter for one raw button.
// The stable output only changes after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   i_clk    : system clock
//   i_rstN   : synchronous active-low reset
//   i_btnRaw : raw asynchronous button, active-high
//   o_stable : debounced button state
// ---------------------------------------------------------------------------
module debounce_cell
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 18
) (
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_btnRaw,
  output logic o_stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // The counter measures how long the synchronized input has continuously
  // disagreed with the accepted state; any agreement restarts the count, so
  // bounces shorter than the window never reach the toggle point.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btnRaw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Turns four bouncy push-buttons into clean, mutually exclusive direction
// levels and single-cycle press pulses for the square-selection logic.
// Each button is debounced independently; an arbiter then grants at most one
// direction at a time, only on a rising debounced edge, with priority
// UP > DOWN > RIGHT > LEFT when edges coincide.
// Optional feature macro: BUTTON_AUTOREPEAT_EN -- while a direction is held,
// its level drops for one cycle after REPEAT_DELAY cycles and then every
// REPEAT_PERIOD cycles, re-asserting with a fresh press pulse.
// Ports:
//   clk25MHz      : system clock, 25 MHz
//   rst_n         : synchronous active-low reset
//   btn_*_raw     : raw asynchronous buttons, active-high
//   up/down/right/left : clean exclusive direction levels
//   press_pulse   : one-cycle grant pulse, bit0 up .. bit3 left
//   busy          : high while any direction is owned
// ---------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 18,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       clk25MHz,
  input  logic       rst_n,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_right_raw,
  input  logic       btn_left_raw,
  output logic       up,
  output logic       down,
  output logic       right,
  output logic       left,
  output logic [3:0] press_pulse,
  output logic       busy
);

  localparam int unsigned HOLD_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

  logic [NUM_DIRS-1:0] w_raw;
  logic [NUM_DIRS-1:0] w_stable;
  logic [NUM_DIRS-1:0] w_rise;
  logic [1:0]          w_grantDir;
  logic [1:0]          w_ownDir;

  logic [2:0]          r_state;
  logic [NUM_DIRS-1:0] r_stablePrev;
  logic [3:0]          r_level;
  logic [3:0]          r_pulse;

`ifdef BUTTON_AUTOREPEAT_EN
  logic [HOLD_W-1:0]   r_hold;
  logic                r_repeated;
  logic [HOLD_W-1:0]   w_holdLimit;
`else
  logic [HOLD_W-1:0]   w_unusedHoldCfg;
  assign w_unusedHoldCfg = '0;
`endif

  assign w_raw = {btn_left_raw, btn_right_raw, btn_down_raw, btn_up_raw};

  for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_cell (
      .i_clk    (clk25MHz),
      .i_rstN   (rst_n),
      .i_btnRaw (w_raw[gi]),
      .o_stable (w_stable[gi])
    );
  end

  // Only fresh debounced presses are candidates; a button that was already
  // down when the arbiter became idle has no rising edge and is ignored.
  assign w_rise   = w_stable & ~r_stablePrev;
  assign w_ownDir = r_state[1:0];

  // Fixed priority among simultaneous rising edges.
  always_comb begin
    w_grantDir = DIR_UP;
    if (w_rise[DIR_UP]) begin
      w_grantDir = DIR_UP;
    end else if (w_rise[DIR_DOWN]) begin
      w_grantDir = DIR_DOWN;
    end else if (w_rise[DIR_RIGHT]) begin
      w_grantDir = DIR_RIGHT;
    end else if (w_rise[DIR_LEFT]) begin
      w_grantDir = DIR_LEFT;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  // First repeat waits the long delay, later ones use the shorter period.
  assign w_holdLimit = r_repeated ? HOLD_W'(REPEAT_PERIOD - 1)
                                  : HOLD_W'(REPEAT_DELAY - 1);
`endif

  // Arbiter: idle until a debounced rising edge, then own that direction
  // until its debounced state falls. Outputs are registered here so the
  // consumer never sees decode glitches, and the return through idle gives
  // at least one all-low cycle between grants.
  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_stablePrev <= '0;
      r_level      <= '0;
      r_pulse      <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
      r_hold       <= '0;
      r_repeated   <= 1'b0;
`endif
    end else begin
      r_stablePrev <= w_stable;
      r_pulse      <= '0;
      if (r_state == ST_IDLE) begin
        if (w_rise != '0) begin
          r_state <= ownState(w_grantDir);
          r_level <= dirMask(w_grantDir);
          r_pulse <= dirMask(w_grantDir);
`ifdef BUTTON_AUTOREPEAT_EN
          r_hold     <= '0;
          r_repeated <= 1'b0;
`endif
        end
      end else if (!w_stable[w_ownDir]) begin
        r_state <= ST_IDLE;
        r_level <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
        r_hold     <= '0;
        r_repeated <= 1'b0;
      end else if (r_hold == w_holdLimit) begin
        r_level    <= '0;
        r_hold     <= '0;
        r_repeated <= 1'b1;
      end else begin
        r_hold <= r_hold + 1'b1;
        if (r_level == '0) begin
          r_level <= dirMask(w_ownDir);
          r_pulse <= dirMask(w_ownDir);
        end
`endif
      end
    end
  end

  assign up          = r_level[DIR_UP];
  assign down        = r_level[DIR_DOWN];
  assign right       = r_level[DIR_RIGHT];
  assign left        = r_level[DIR_LEFT];
  assign press_pulse = r_pulse;
  assign busy        = ~r_state[2];

endmodule
